pipeline_hazard_controller: RTL and testbench
=============================================

# pipeline_hazard_controller

Central stall/flush sequencer for the 5-stage pipelined core. Combines load-use hazard detection, taken-branch flushing and data-memory wait handling into one prioritised set of per-stage write-enable and flush controls. It also runs a small FSM that freezes the whole pipeline while data memory is busy, and latches a sticky error if memory never answers. Sits beside the pipeline registers and drives their enables and flushes directly.

## Interface
Parameters:
- MEM_TIMEOUT, 16: maximum consecutive wait cycles tolerated in MEM_WAIT before error (≥2).
- CNT_W, 32: width of performance counters.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- if_id_rs1_addr  in  5  rs1 of instruction in ID.
- if_id_rs2_addr  in  5  rs2 of instruction in ID.
- id_ex_rd_addr  in  5  rd of instruction in EX.
- id_ex_mem_read  in  1  instruction in EX is a load.
- ex_branch_taken  in  1  branch/jump in EX resolved taken.
- dmem_req  in  1  MEM stage holds a load/store this cycle.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_we  out  1  PC write enable.
- if_id_we  out  1  IF/ID write enable.
- if_id_flush  out  1  IF/ID cleared to NOP.
- id_ex_we  out  1  ID/EX write enable.
- id_ex_flush  out  1  ID/EX loaded with bubble.
- ex_mem_we  out  1  EX/MEM write enable.
- mem_wb_flush  out  1  MEM/WB loaded with bubble.
- stall  out  1  OR of all hold conditions.
- mem_timeout_err  out  1  sticky timeout flag.
- load_use_cnt, flush_cnt, mem_wait_cnt  out  CNT_W  performance counters.

## Operation
- FSM states: RUN, MEM_WAIT, ERR. Reset → RUN, wait counter 0, error 0, perf counters 0.
- Hazard terms (combinational):
  - mem_hold = dmem_req & ~dmem_ready in RUN/MEM_WAIT; forced 1 in ERR.
  - branch = ex_branch_taken & ~mem_hold.
  - load_use = id_ex_mem_read & (id_ex_rd_addr != 0) & (rd == rs1 | rd == rs2) & ~mem_hold & ~branch.
- Priority: mem_hold > branch > load_use.
- mem_hold: pc_we = if_id_we = id_ex_we = ex_mem_we = 0; mem_wb_flush = 1; other flushes 0.
- branch: all we = 1; if_id_flush = id_ex_flush = 1. A branch already in EX overrides its own load-use.
- load_use: pc_we = if_id_we = 0; id_ex_flush = 1; ex_mem_we = 1.
- None active: all we = 1, all flushes 0, stall = 0.
- stall = mem_hold | load_use.
- Transitions:
  - RUN → MEM_WAIT when mem_hold.
  - MEM_WAIT → RUN on dmem_ready.
  - MEM_WAIT → ERR when the wait counter reaches MEM_TIMEOUT−1 with dmem_ready still low.
  - ERR persists until reset.
- Wait counter: cleared in RUN, increments each MEM_WAIT cycle, saturates.
- mem_timeout_err = (state == ERR).
- dmem_req low while in MEM_WAIT is treated as completion: return to RUN.

## Timing
- All control outputs are combinational from the current state and inputs; they act in the same cycle as the hazard.
- Load-use: exactly 1 bubble cycle. The next cycle, rd is in MEM, so the term is false.
- Branch: 1 cycle of flush, which kills 2 younger instructions.
- Memory wait: freeze covers every cycle with dmem_ready = 0. A single-cycle access with dmem_ready = 1 in the same cycle as dmem_req causes no stall.
- A branch or load-use coinciding with mem_hold is not lost. EX is frozen, so the condition re-presents once the freeze ends.
- ERR is entered on the edge after wait cycle MEM_TIMEOUT. From that cycle, all outputs are frozen and mem_timeout_err = 1.
- Reset asserted mid-wait or in ERR returns to RUN on the next edge. Outputs at reset are the "none active" values, with err = 0.

## Configuration
- HAZ_PERF_CNT_EN defined: counters are implemented, and each saturates at all-ones.
  - load_use_cnt increments per load_use cycle.
  - flush_cnt increments per branch cycle.
  - mem_wait_cnt increments per mem_hold cycle in RUN/MEM_WAIT.
- Not defined: the counter ports remain and are tied to 0. No counter flops are instantiated.

## Test plan
- Load x5, then add x6,x5,x1 in ID: 1 cycle with pc_we = 0, if_id_we = 0, id_ex_flush = 1; next cycle all enables 1. With rd = x0: no stall.
- ex_branch_taken = 1 while a load-use condition also holds: if_id_flush = id_ex_flush = 1, pc_we = 1, load_use_cnt unchanged.
- dmem_req = 1, dmem_ready low for 3 cycles then high: 3 freeze cycles with mem_wb_flush = 1. The ready cycle has no stall, and the state returns to RUN. mem_wait_cnt = 3.
- MEM_TIMEOUT = 4, dmem_ready never asserted: mem_timeout_err = 1 after 4 wait cycles, and the freeze holds indefinitely.
- Reset pulse (rst_n = 0 for 1 cycle) in ERR: next cycle state is RUN, mem_timeout_err = 0, all enables 1.
- ex_branch_taken during a memory wait: no flush until the wait ends, then exactly 1 flush cycle.

Source files
------------

// File: rtl/pipeline_hazard_controller_if.sv
// Pipeline hazard control bundle: hazard inputs from the pipeline, stage enables/flushes back.
// master = hazard controller side, slave = pipeline register side.
interface pipeline_hazard_controller_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       if_id_rs1_addr;
    logic [4:0]       if_id_rs2_addr;
    logic [4:0]       id_ex_rd_addr;
    logic             id_ex_mem_read;
    logic             ex_branch_taken;
    logic             dmem_req;
    logic             dmem_ready;
    logic             pc_we;
    logic             if_id_we;
    logic             if_id_flush;
    logic             id_ex_we;
    logic             id_ex_flush;
    logic             ex_mem_we;
    logic             mem_wb_flush;
    logic             stall;
    logic             mem_timeout_err;
    logic [CNT_W-1:0] load_use_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] mem_wait_cnt;

    modport master (
        input  if_id_rs1_addr, if_id_rs2_addr, id_ex_rd_addr, id_ex_mem_read,
               ex_branch_taken, dmem_req, dmem_ready,
        output pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we,
               mem_wb_flush, stall, mem_timeout_err, load_use_cnt, flush_cnt, mem_wait_cnt
    );

    modport slave (
        output if_id_rs1_addr, if_id_rs2_addr, id_ex_rd_addr, id_ex_mem_read,
               ex_branch_taken, dmem_req, dmem_ready,
        input  pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we,
               mem_wb_flush, stall, mem_timeout_err, load_use_cnt, flush_cnt, mem_wait_cnt
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Purpose: prioritised stall/flush sequencer (mem wait > taken branch > load-use) with memory-timeout FSM.
// Latency: all enables/flushes combinational, same cycle as the hazard; FSM and counters update on clk.
// Backpressure: a pending dmem access freezes every stage; timeout latches ERR until rst_n. Counters: HAZ_PERF_CNT_EN.
module pipeline_hazard_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    pipeline_hazard_controller_if.master hz
);
    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR      = 2'd2;
    localparam int         WCNT_W      = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [WCNT_W-1:0] wait_cnt;
    logic [WCNT_W-1:0] wait_cnt_inc;
    logic              mem_hold;
    logic              branch;
    logic              load_use;
    logic              rd_match;

    always_comb begin
        mem_hold = (state == ST_ERR) | (hz.dmem_req & ~hz.dmem_ready);
        branch   = hz.ex_branch_taken & ~mem_hold;
        rd_match = (hz.id_ex_rd_addr == hz.if_id_rs1_addr) | (hz.id_ex_rd_addr == hz.if_id_rs2_addr);
        load_use = hz.id_ex_mem_read & (hz.id_ex_rd_addr != 5'd0) & rd_match & ~mem_hold & ~branch;
    end

    // A load-use bubble keeps ID/EX writing so the bubble actually lands in EX.
    assign hz.pc_we           = ~mem_hold & ~load_use;
    assign hz.if_id_we        = ~mem_hold & ~load_use;
    assign hz.id_ex_we        = ~mem_hold;
    assign hz.ex_mem_we       = ~mem_hold;
    assign hz.if_id_flush     = branch;
    assign hz.id_ex_flush     = branch | load_use;
    assign hz.mem_wb_flush    = mem_hold;
    assign hz.stall           = mem_hold | load_use;
    assign hz.mem_timeout_err = (state == ST_ERR);

    assign wait_cnt_inc = wait_cnt + WCNT_W'(1);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:      if (mem_hold) state_nxt = ST_MEM_WAIT;
            ST_MEM_WAIT: begin
                // Dropping dmem_req mid-wait counts as completion.
                if (!hz.dmem_req || hz.dmem_ready) state_nxt = ST_RUN;
                else if (wait_cnt_inc >= WAIT_LAST) state_nxt = ST_ERR;
            end
            ST_ERR:      state_nxt = ST_ERR;
            default:     state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_RUN) begin
                wait_cnt <= '0;
            end else if (state == ST_MEM_WAIT && wait_cnt != WAIT_LAST) begin
                wait_cnt <= wait_cnt_inc;
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] load_use_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] mem_wait_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            load_use_cnt_q <= '0;
            flush_cnt_q    <= '0;
            mem_wait_cnt_q <= '0;
        end else begin
            if (load_use && load_use_cnt_q != '1) load_use_cnt_q <= load_use_cnt_q + CNT_W'(1);
            if (branch && flush_cnt_q != '1)      flush_cnt_q    <= flush_cnt_q + CNT_W'(1);
            if (mem_hold && state != ST_ERR && mem_wait_cnt_q != '1)
                mem_wait_cnt_q <= mem_wait_cnt_q + CNT_W'(1);
        end
    end

    assign hz.load_use_cnt = load_use_cnt_q;
    assign hz.flush_cnt    = flush_cnt_q;
    assign hz.mem_wait_cnt = mem_wait_cnt_q;
`else
    assign hz.load_use_cnt = {CNT_W{1'b0}};
    assign hz.flush_cnt    = {CNT_W{1'b0}};
    assign hz.mem_wait_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller with MEM_TIMEOUT = 4.
// Control outputs packed as {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_flush, stall, err}.
module tb_pipeline_hazard_controller;
    localparam int TO    = 4;
    localparam int CNT_W = 32;
`ifdef HAZ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [8:0] C_NONE = 9'b1_1_0_1_0_1_0_0_0;
    localparam logic [8:0] C_LU   = 9'b0_0_0_1_1_1_0_1_0;
    localparam logic [8:0] C_BR   = 9'b1_1_1_1_1_1_0_0_0;
    localparam logic [8:0] C_HOLD = 9'b0_0_0_0_0_0_1_1_0;
    localparam logic [8:0] C_ERR  = 9'b0_0_0_0_0_0_1_1_1;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       mr;
        logic       br;
        logic       req;
        logic       rdy;
        logic [8:0] exp;
    } vec_t;

    logic clk;
    logic rst_n;
    pipeline_hazard_controller_if #(.CNT_W(CNT_W)) hz();

    pipeline_hazard_controller #(.MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         vectors = 0;
    int         miscompares = 0;
    logic [8:0] sb[$];
    logic [8:0] exp_ctl;
    int         m_lu = 0;
    int         m_fl = 0;
    int         m_mw = 0;

    function automatic logic [8:0] ctl_obs();
        return {hz.pc_we, hz.if_id_we, hz.if_id_flush, hz.id_ex_we, hz.id_ex_flush,
                hz.ex_mem_we, hz.mem_wb_flush, hz.stall, hz.mem_timeout_err};
    endfunction

    function automatic logic [CNT_W-1:0] exp_cnt(input int v);
        return PERF ? CNT_W'(v) : '0;
    endfunction

    // Drive one cycle of inputs and push its expected controls; counter model follows the expectation.
    task automatic apply(input vec_t v);
        hz.if_id_rs1_addr  = v.rs1;
        hz.if_id_rs2_addr  = v.rs2;
        hz.id_ex_rd_addr   = v.rd;
        hz.id_ex_mem_read  = v.mr;
        hz.ex_branch_taken = v.br;
        hz.dmem_req        = v.req;
        hz.dmem_ready      = v.rdy;
        sb.push_back(v.exp);
        if (v.exp == C_LU)   m_lu++;
        if (v.exp == C_BR)   m_fl++;
        if (v.exp == C_HOLD) m_mw++;
    endtask

    task automatic test_reset();
        vec_t idle;
        idle = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE};
        rst_n = 1'b0;
        hz.if_id_rs1_addr = '0; hz.if_id_rs2_addr = '0; hz.id_ex_rd_addr = '0;
        hz.id_ex_mem_read = 1'b0; hz.ex_branch_taken = 1'b0; hz.dmem_req = 1'b0; hz.dmem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        apply(idle);
        @(negedge clk);
        exp_ctl = sb.pop_front();
        vectors++;
        if (ctl_obs() !== exp_ctl) begin
            $display("FAIL reset_ctl got=%b want=%b", ctl_obs(), exp_ctl);
            miscompares++;
        end
        vectors++;
        if ({hz.load_use_cnt, hz.flush_cnt, hz.mem_wait_cnt} !== '0) begin
            $display("FAIL reset_cnt got=%0d/%0d/%0d want=0/0/0", hz.load_use_cnt, hz.flush_cnt, hz.mem_wait_cnt);
            miscompares++;
        end
        @(posedge clk); #1;
    endtask

    task automatic run_table(input string name, input vec_t tbl[]);
        foreach (tbl[i]) begin
            apply(tbl[i]);
            @(negedge clk);
            exp_ctl = sb.pop_front();
            vectors++;
            if (ctl_obs() !== exp_ctl) begin
                $display("FAIL %s[%0d] got=%b want=%b", name, i, ctl_obs(), exp_ctl);
                miscompares++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        vec_t t[];
        t = new[5];
        t[0] = '{5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, C_LU};
        t[1] = '{5'd2, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE};
        t[2] = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, C_NONE};
        t[3] = '{5'd3, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, C_LU};
        t[4] = '{5'd3, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE};
        run_table("load_use", t);
        vectors++;
        if (hz.load_use_cnt !== exp_cnt(m_lu)) begin
            $display("FAIL load_use_cnt got=%0d want=%0d", hz.load_use_cnt, exp_cnt(m_lu));
            miscompares++;
        end
    endtask

    task automatic test_branch_priority();
        vec_t t[];
        t = new[4];
        t[0] = '{5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, C_BR};
        t[1] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, C_BR};
        t[2] = '{5'd1, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, C_LU};
        t[3] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE};
        run_table("branch", t);
        vectors++;
        if (hz.flush_cnt !== exp_cnt(m_fl)) begin
            $display("FAIL flush_cnt got=%0d want=%0d", hz.flush_cnt, exp_cnt(m_fl));
            miscompares++;
        end
        vectors++;
        if (hz.load_use_cnt !== exp_cnt(m_lu)) begin
            $display("FAIL branch_lu_cnt got=%0d want=%0d", hz.load_use_cnt, exp_cnt(m_lu));
            miscompares++;
        end
    endtask

    task automatic test_mem_wait();
        vec_t t[];
        int   mw0;
        mw0 = m_mw;
        t = new[4];
        t[0] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_HOLD};
        t[1] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_HOLD};
        t[2] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_HOLD};
        t[3] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, C_NONE};
        run_table("mem_wait", t);
        vectors++;
        if (hz.mem_wait_cnt !== exp_cnt(m_mw)) begin
            $display("FAIL mem_wait_cnt got=%0d want=%0d (burst of %0d)", hz.mem_wait_cnt, exp_cnt(m_mw), m_mw - mw0);
            miscompares++;
        end
        // Second burst only survives if the wait counter was cleared back in RUN.
        t = new[9];
        t[0] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, C_NONE};
        t[1] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_HOLD};
        t[2] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_HOLD};
        t[3] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_HOLD};
        t[4] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, C_NONE};
        t[5] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_HOLD};
        t[6] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_HOLD};
        t[7] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE};
        t[8] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, C_NONE};
        run_table("mem_wait2", t);
        vectors++;
        if (hz.mem_wait_cnt !== exp_cnt(m_mw)) begin
            $display("FAIL mem_wait_cnt2 got=%0d want=%0d", hz.mem_wait_cnt, exp_cnt(m_mw));
            miscompares++;
        end
    endtask

    task automatic test_branch_during_wait();
        vec_t t[];
        t = new[7];
        t[0] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, C_HOLD};
        t[1] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, C_HOLD};
        t[2] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, C_BR};
        t[3] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE};
        t[4] = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, C_HOLD};
        t[5] = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, C_LU};
        t[6] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE};
        run_table("br_in_wait", t);
        vectors++;
        if (hz.flush_cnt !== exp_cnt(m_fl)) begin
            $display("FAIL br_in_wait_flush_cnt got=%0d want=%0d", hz.flush_cnt, exp_cnt(m_fl));
            miscompares++;
        end
    endtask

    task automatic test_timeout();
        vec_t t[];
        t = new[8];
        for (int i = 0; i < TO; i++) t[i] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_HOLD};
        t[4] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_ERR};
        t[5] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_ERR};
        t[6] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, C_ERR};
        t[7] = '{5'd4, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, C_ERR};
        run_table("timeout", t);
        vectors++;
        if (hz.mem_wait_cnt !== exp_cnt(m_mw)) begin
            $display("FAIL timeout_mw_cnt got=%0d want=%0d", hz.mem_wait_cnt, exp_cnt(m_mw));
            miscompares++;
        end
    endtask

    task automatic test_reset_in_err();
        vec_t t[];
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        m_lu = 0; m_fl = 0; m_mw = 0;
        t = new[3];
        t[0] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE};
        t[1] = '{5'd8, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, C_LU};
        t[2] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, C_NONE};
        run_table("rst_in_err", t);
        vectors++;
        if ({hz.load_use_cnt, hz.flush_cnt, hz.mem_wait_cnt} !== {exp_cnt(m_lu), exp_cnt(m_fl), exp_cnt(m_mw)}) begin
            $display("FAIL rst_in_err_cnt got=%0d/%0d/%0d want=%0d/%0d/%0d", hz.load_use_cnt, hz.flush_cnt,
                     hz.mem_wait_cnt, exp_cnt(m_lu), exp_cnt(m_fl), exp_cnt(m_mw));
            miscompares++;
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_priority();
        test_mem_wait();
        test_branch_during_wait();
        test_timeout();
        test_reset_in_err();
        vectors++;
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
